// File: rtl/adder_eval_pkg.sv
// Shared definitions for the approximate-adder evaluation blocks:
// monitor state encoding and default operand widths.
package adder_eval_pkg;

  localparam int ADDER_W  = 8;
  localparam int ADDER_OW = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } mon_state_t;

endpackage

// File: rtl/adder_error_monitor_if.sv
// Sample bus between the stimulus source and the error monitor:
// operand pair plus the approximate sum, qualified by a valid/ready handshake.
interface adder_error_monitor_if
  import adder_eval_pkg::*;
#(
  parameter int W = ADDER_W
) ();

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [W:0]   approx_sum;

  modport master (
    output in_valid,
    output op_a,
    output op_b,
    output approx_sum,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  op_a,
    input  op_b,
    input  approx_sum,
    output in_ready
  );

endinterface

// File: rtl/adder_error_monitor_err_distance.sv
// Combinational error evaluation of one sample: exact sum of the operands,
// absolute distance to the approximate sum, and a mismatch flag.
module err_distance
  import adder_eval_pkg::*;
#(
  parameter int W = ADDER_W
) (
  input  logic [W-1:0] op_a_i,
  input  logic [W-1:0] op_b_i,
  input  logic [W:0]   approx_i,
  output logic [W:0]   ed_o,
  output logic         mismatch_o
);

  logic [W:0] exact;

  always_comb begin
    exact      = {1'b0, op_a_i} + {1'b0, op_b_i};
    ed_o       = (exact >= approx_i) ? (exact - approx_i) : (approx_i - exact);
    mismatch_o = (exact != approx_i);
  end

endmodule

// File: rtl/adder_error_monitor.sv
// Error monitor for the approximate adder: accepts a programmed number of samples,
// evaluates each through a two-stage pipeline and accumulates error statistics.
//
//   state | meaning
//   IDLE  | waiting for start after reset
//   RUN   | accepting samples, in_ready high
//   DRAIN | all samples accepted, waiting for the pipeline to retire them
//   DONE  | statistics final and held until the next start
module adder_error_monitor
  import adder_eval_pkg::*;
#(
  parameter int W     = ADDER_W,
  parameter int CNT_W = 32,
  parameter int SUM_W = 40
) (
  input  logic                 clk,
  input  logic                 rst,
  adder_error_monitor_if.slave bus_if,
  input  logic                 start_i,
  input  logic [CNT_W-1:0]     sample_count_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CNT_W-1:0]     err_count_o,
  output logic [W:0]           max_ed_o,
  output logic [SUM_W-1:0]     sum_ed_o,
  output logic                 last_mismatch_o
);

  // One spare bit above the wider of accumulator and ED catches the saturation carry.
  localparam int ACC_W = ((SUM_W > W + 1) ? SUM_W : W + 1) + 1;
  localparam logic [SUM_W-1:0] SUM_MAX = {SUM_W{1'b1}};

  mon_state_t       state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             in_ready_q;
  logic             xfer;
  logic             clear_stats;

  logic             s1_valid_q;
  logic [W-1:0]     s1_a_q, s1_b_q;
  logic [W:0]       s1_approx_q;
  logic [W:0]       ed;
  logic             mismatch;

  logic             s2_valid_q;
  logic [W:0]       s2_ed_q;
  logic             s2_mismatch_q;

  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [W:0]       max_ed_q, max_ed_d;
  logic [SUM_W-1:0] sum_ed_q, sum_ed_d;
  logic             last_mismatch_q, last_mismatch_d;
  logic [ACC_W-1:0] acc_sum;

  assign xfer = bus_if.in_valid & in_ready_q;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    clear_stats = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          clear_stats = 1'b1;
          remaining_d = sample_count_i;
          state_d     = (sample_count_i == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (xfer) begin
          remaining_d = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Stage 2 retires the last sample on this edge once stage 1 is empty.
        if (!s1_valid_q) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      in_ready_q  <= (state_d == RUN);
    end
  end

  err_distance #(
    .W (W)
  ) u_err_distance (
    .op_a_i     (s1_a_q),
    .op_b_i     (s1_b_q),
    .approx_i   (s1_approx_q),
    .ed_o       (ed),
    .mismatch_o (mismatch)
  );

  always_comb begin
    err_count_d     = err_count_q;
    max_ed_d        = max_ed_q;
    sum_ed_d        = sum_ed_q;
    last_mismatch_d = last_mismatch_q;
    acc_sum         = ACC_W'(sum_ed_q) + ACC_W'(s2_ed_q);
    if (clear_stats) begin
      err_count_d     = '0;
      max_ed_d        = '0;
      sum_ed_d        = '0;
      last_mismatch_d = 1'b0;
    end else if (s2_valid_q) begin
      err_count_d     = err_count_q + CNT_W'(s2_mismatch_q);
      max_ed_d        = (s2_ed_q > max_ed_q) ? s2_ed_q : max_ed_q;
      sum_ed_d        = (acc_sum > ACC_W'(SUM_MAX)) ? SUM_MAX : acc_sum[SUM_W-1:0];
      last_mismatch_d = s2_mismatch_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q      <= 1'b0;
      s1_a_q          <= '0;
      s1_b_q          <= '0;
      s1_approx_q     <= '0;
      s2_valid_q      <= 1'b0;
      s2_ed_q         <= '0;
      s2_mismatch_q   <= 1'b0;
      err_count_q     <= '0;
      max_ed_q        <= '0;
      sum_ed_q        <= '0;
      last_mismatch_q <= 1'b0;
    end else begin
      s1_valid_q <= xfer;
      if (xfer) begin
        s1_a_q      <= bus_if.op_a;
        s1_b_q      <= bus_if.op_b;
        s1_approx_q <= bus_if.approx_sum;
      end
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_ed_q       <= ed;
        s2_mismatch_q <= mismatch;
      end
      err_count_q     <= err_count_d;
      max_ed_q        <= max_ed_d;
      sum_ed_q        <= sum_ed_d;
      last_mismatch_q <= last_mismatch_d;
    end
  end

  assign bus_if.in_ready = in_ready_q;
  assign busy_o          = (state_q == RUN) || (state_q == DRAIN);
  assign done_o          = (state_q == DONE);
  assign err_count_o     = err_count_q;
  assign max_ed_o        = max_ed_q;
  assign sum_ed_o        = sum_ed_q;
  assign last_mismatch_o = last_mismatch_q;

endmodule

// File: doc/adder_error_monitor.md
# adder_error_monitor

Sequential error-evaluation block for the approximate adder benches. It consumes the opposite end of the adder interface: it receives operand pairs together with the sum produced by the approximate 8-bit adder under test, recomputes the exact sum, and accumulates error statistics over a programmed number of samples. It sits between the stimulus source and the result collector in the QoR evaluation flow, with a valid/ready handshake on its input side.

## Interface
- `W`, 8: operand width.
- `CNT_W`, 32: width of the sample counter and `err_count`.
- `SUM_W`, 40: width of the saturating `sum_ed` accumulator.
- `clk` input 1: clock, rising-edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: single-cycle pulse; arms a run. Honoured only in IDLE or DONE.
- `sample_count` input CNT_W: number of samples in the run; captured on `start`.
- `in_valid` input 1: the sample on `op_a`/`op_b`/`approx_sum` is valid.
- `in_ready` output 1: the block accepts the sample this cycle.
- `op_a`, `op_b` input W: operands as applied to the adder.
- `approx_sum` input W+1: adder output; the MSB is the carry-out.
- `busy` output 1: high in RUN and DRAIN.
- `done` output 1: high while in DONE.
- `err_count` output CNT_W: number of samples with `approx_sum` ≠ exact sum.
- `max_ed` output W+1: largest error distance seen in the run.
- `sum_ed` output SUM_W: sum of error distances, saturating at all-ones.
- `last_mismatch` output 1: the most recently retired sample was erroneous.

## Operation
- FSM states: IDLE → RUN → DRAIN → DONE.
- IDLE/DONE + `start`:
  - clear `err_count`, `max_ed`, `sum_ed` and `last_mismatch`;
  - load `remaining` = `sample_count`;
  - go to RUN, or go directly to DONE when `sample_count` = 0.
- RUN: `in_ready` = 1. A sample transfers when `in_valid && in_ready`. Each transfer decrements `remaining`. Go to DRAIN in the cycle after the transfer that makes `remaining` 0.
- DRAIN: `in_ready` = 0. Go to DONE once the pipeline is empty.
- DONE holds the results until the next `start` or `rst`.
- `start` in RUN or DRAIN is ignored.
- Pipeline stage 1 registers:
  - exact = `op_a` + `op_b`, at W+1 bits with no overflow possible;
  - `approx_sum`;
  - a valid bit.
- Pipeline stage 2 computes ED = |exact − approx| as an unsigned W+1-bit value. It then updates the statistics:
  - `err_count` += (ED ≠ 0);
  - `max_ed` = max(`max_ed`, ED);
  - `sum_ed` += ED, clamped at 2^SUM_W − 1;
  - `last_mismatch` = (ED ≠ 0).
- `err_count` cannot overflow because it is bounded by `sample_count`.
- Reset values are 0 for every output, including `in_ready`; the FSM resets to IDLE.
- `rst` asserted mid-run aborts the run immediately. In-flight samples are discarded and no partial statistics remain.

## Timing
- `in_ready` is a registered function of the state only. It never depends on `in_valid` in the same cycle.
- Throughput is 1 sample per cycle in RUN.
- A sample accepted at edge N is reflected in the statistics after edge N+2.
- `busy` falls and `done` rises at the edge that retires the last sample: 2 cycles after the final transfer.
- With `sample_count` = 0, `done` = 1 one cycle after `start`.
- Gaps in `in_valid` only stall the run. There is no timeout.

## Structure
- The shared package `adder_eval_pkg` holds:
  - the state enum `mon_state_t` (IDLE, RUN, DRAIN, DONE);
  - the default width constants `ADDER_W` = 8 and `ADDER_OW` = 9.
- One sub-module, `err_distance`: combinational, computing exact sum, ED and mismatch from (`op_a`, `op_b`, `approx_sum`). The stage-1/stage-2 registers and the FSM stay in the top level.

## Test plan
- Exact reference model as DUT, 256 random samples, `sample_count` = 256 → `done`; `err_count` = 0, `max_ed` = 0, `sum_ed` = 0.
- Samples a=0xFF/b=0x01/approx=0x000 and a=0x10/b=0x10/approx=0x021 with `sample_count` = 2 → `err_count` = 2, `max_ed` = 256, `sum_ed` = 257, `last_mismatch` = 1.
- `sample_count` = 0, `start` → `done` = 1 next cycle, all statistics 0, `in_ready` never 1.
- `sample_count` = 4 with `in_valid` toggling 1,0,0,1,1,0,1 → exactly 4 transfers; `in_ready` = 0 from DRAIN on; `done` 2 cycles after the 4th transfer.
- `rst` asserted two cycles into a 10-sample run → next cycle all outputs 0, state IDLE. A following `start` runs cleanly.
- `SUM_W` = 4, three samples with ED = 7 → `sum_ed` = 15 (saturated), `max_ed` = 7, `err_count` = 3. `start` pulses during RUN are ignored.
